// File: rtl/mp3_pkg.sv
// mp3_pkg
//   Constants and small types shared along the MP3 frame path (side-info
//   parser, main-data reservoir, Huffman/scalefactor decoder).
//   No ports; import with `import mp3_pkg::*;`.
package mp3_pkg;

  localparam int MAIN_DATA_BEGIN_W = 9;
  localparam int BYTE_W            = 8;
  localparam int RESERVOIR_DEPTH   = 4096;

  typedef logic [BYTE_W-1:0]            mp3_byte_t;
  typedef logic [MAIN_DATA_BEGIN_W-1:0] mdb_t;

endpackage

// File: rtl/reservoir_skid_fifo.sv
// reservoir_skid_fifo
//   Two-entry valid/ready output buffer for the bit reservoir. The head entry
//   drives the output directly from a register, so data and valid stay stable
//   while the consumer stalls. A flush empties the buffer in one cycle.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop every buffered entry (wins over push/pop)
//   in_valid, in_data   byte returned by the reservoir RAM
//   out_valid, out_data head of the buffer
//   out_ready           consumer accepts the head this cycle
//   count               current number of buffered entries (0..2)
module reservoir_skid_fifo
  import mp3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic [BYTE_W-1:0] head_r;
  logic [BYTE_W-1:0] tail_r;
  logic [1:0]        count_r;
  logic              pop_s;
  logic              push_s;

  // Handshake decode; a push is only taken when a slot is (or becomes) free
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    pop_s  = (count_r != 2'd0) && out_ready;
    push_s = in_valid && ((count_r != 2'd2) || pop_s);
  end

  // Entry storage and occupancy count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= {BYTE_W{1'b0}};
      tail_r  <= {BYTE_W{1'b0}};
      count_r <= 2'd0;
    end else if (flush) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= in_data;
          end else begin
            tail_r <= in_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new byte lands behind whatever remains
          if (count_r == 2'd1) begin
            head_r <= in_data;
          end else begin
            head_r <= tail_r;
            tail_r <= in_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;
  assign count     = count_r;

endmodule

// File: rtl/main_data_reservoir.sv
// main_data_reservoir
//   Circular bit reservoir for MP3 main data. Bytes from the demultiplexer are
//   written into a DEPTH-byte ring. On each frame_start the read pointer is
//   rewound main_data_begin bytes behind the write point and the frame's main
//   data is streamed out over a valid/ready byte interface.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   axiid, axiiv        incoming main-data byte and its write strobe
//   frame_start         one-cycle pulse: new frame side info is valid
//   main_data_begin     look-back in bytes, sampled with frame_start
//   axiod, axiov, axior output byte, valid, downstream ready
//   fill                bytes available for look-back, saturates at DEPTH-1
//   underflow           sticky: a look-back exceeded fill
//   overflow            sticky: a write was dropped to protect unread bytes
module main_data_reservoir
  import mp3_pkg::*;
#(
  parameter  int DEPTH = RESERVOIR_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BYTE_W-1:0]            axiid,
  input  logic                         axiiv,
  input  logic                         frame_start,
  input  logic [MAIN_DATA_BEGIN_W-1:0] main_data_begin,
  output logic [BYTE_W-1:0]            axiod,
  output logic                         axiov,
  input  logic                         axior,
  output logic [AW:0]                  fill,
  output logic                         underflow,
  output logic                         overflow
);

  localparam logic [0:0]    ST_IDLE    = 1'b0;
  localparam logic [0:0]    ST_STREAM  = 1'b1;
  localparam logic [AW:0]   FILL_MAX   = (AW+1)'(DEPTH-1);
  localparam logic [AW:0]   FILL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] UNREAD_MAX = {AW{1'b1}};

  mp3_byte_t         mem_r [DEPTH];
  mp3_byte_t         rdata_r;
  logic [AW-1:0]     wp_r;
  logic [AW-1:0]     rp_r;
  logic [AW:0]       fill_r;
  logic [0:0]        state_r;
  logic              underflow_r;
  logic              overflow_r;
  logic              inflight_r;

  logic [AW-1:0]     unread_s;
  logic [AW-1:0]     fs_rp_s;
  logic [AW-1:0]     rd_addr_s;
  logic              drop_s;
  logic              wr_en_s;
  logic              lookback_ok_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic [1:0]        fifo_cnt_s;
  logic [2:0]        occupancy_s;

  // Write acceptance and frame-start rewind target
  always_comb begin
    unread_s      = {AW{1'b0}};
    drop_s        = 1'b0;
    wr_en_s       = 1'b0;
    lookback_ok_s = 1'b0;
    fs_rp_s       = {AW{1'b0}};
    unread_s      = wp_r - rp_r;
    // A full ring of unread bytes means the next write would clobber rp
    drop_s        = axiiv && (state_r == ST_STREAM) && (unread_s == UNREAD_MAX);
    wr_en_s       = axiiv && !drop_s;
    lookback_ok_s = ({{(AW+1-MAIN_DATA_BEGIN_W){1'b0}}, main_data_begin} <= fill_r);
    // Rewind uses wp before any same-cycle write, so that byte joins the frame
    if (lookback_ok_s) begin
      fs_rp_s = wp_r - {{(AW-MAIN_DATA_BEGIN_W){1'b0}}, main_data_begin};
    end else begin
      fs_rp_s = wp_r;
    end
  end

  // Read issue: counts buffered plus in-flight bytes so a returning byte
  // always has a slot. On frame_start the read at the new rp starts in the
  // same cycle, which gives the two-cycle pulse-to-valid latency.
  always_comb begin
    rd_addr_s   = rp_r;
    issue_s     = 1'b0;
    pop_s       = axiov && axior;
    occupancy_s = {1'b0, fifo_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (frame_start) begin
      rd_addr_s = fs_rp_s;
      issue_s   = (fs_rp_s != wp_r);
    end else if (state_r == ST_STREAM) begin
      rd_addr_s = rp_r;
      issue_s   = (rp_r != wp_r) && (occupancy_s < 3'd2);
    end else begin
      rd_addr_s = rp_r;
      issue_s   = 1'b0;
    end
    // A frame_start discards the read returning this cycle
    push_s = inflight_r && !frame_start;
  end

  // Reservoir RAM: one write port, one registered read port (no reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wp_r] <= axiid;
    end
    if (issue_s) begin
      rdata_r <= mem_r[rd_addr_s];
    end
  end

  // Pointers, fill level, reader state and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_r        <= {AW{1'b0}};
      rp_r        <= {AW{1'b0}};
      fill_r      <= {(AW+1){1'b0}};
      state_r     <= ST_IDLE;
      underflow_r <= 1'b0;
      overflow_r  <= 1'b0;
      inflight_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wp_r <= wp_r + PTR_ONE;
        if (fill_r != FILL_MAX) begin
          fill_r <= fill_r + FILL_ONE;
        end
      end
      if (frame_start) begin
        state_r <= ST_STREAM;
        rp_r    <= issue_s ? (fs_rp_s + PTR_ONE) : fs_rp_s;
        if (!lookback_ok_s) begin
          underflow_r <= 1'b1;
        end
      end else if (issue_s) begin
        rp_r <= rp_r + PTR_ONE;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      inflight_r <= issue_s;
    end
  end

  reservoir_skid_fifo u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (frame_start),
    .in_valid  (push_s),
    .in_data   (rdata_r),
    .out_valid (axiov),
    .out_data  (axiod),
    .out_ready (axior),
    .count     (fifo_cnt_s)
  );

  assign fill      = fill_r;
  assign underflow = underflow_r;
  assign overflow  = overflow_r;

endmodule
